// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame link: header bytes, payload geometry,
// parser states and the XOR checksum also used by the transmit framer.
package uart_frame_pkg;

  localparam logic [7:0]  UART_HDR0        = 8'h4D;
  localparam logic [7:0]  UART_HDR1        = 8'h43;
  localparam int unsigned FRAME_DATA_BYTES = 8;
  localparam int unsigned FRAME_DATA_W     = FRAME_DATA_BYTES * 8;
  localparam int unsigned BYTE_CNT_W       = $clog2(FRAME_DATA_BYTES);

  typedef logic [FRAME_DATA_W-1:0] frame_data_t;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } frame_state_e;

  // XOR of all payload bytes; order-independent so byte ordering never matters.
  function automatic logic [7:0] frame_xor(input frame_data_t data);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < int'(FRAME_DATA_BYTES); i++) begin
      acc = acc ^ data[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog for the frame parser: counts idle cycles while a frame is
// in progress and flags expiry; TIMEOUT_CYCLES = 0 disables it.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic byte_valid_i,
  output logic expire_c
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic               TMO_EN     = (TIMEOUT_CYCLES != 0);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  // A byte arriving in the expiry cycle suppresses the expiry.
  assign expire_c = TMO_EN && active_i && !byte_valid_i && (timer_q == TIMER_LAST);

  // Saturating count so a disabled timer never wraps into a false expiry.
  always_comb begin
    timer_d = timer_q;
    if (!active_i || byte_valid_i || expire_c) begin
      timer_d = '0;
    end else if (timer_q != TIMER_LAST) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART receive framer: hunts for HDR0 HDR1, assembles 8 payload bytes MSB first
// and offers them on a valid/ready port. FRAME_CHECKSUM_EN adds a trailing XOR byte.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  HDR0           = UART_HDR0,
  parameter logic [7:0]  HDR1           = UART_HDR1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [FRAME_DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic                    err_checksum
);

  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(FRAME_DATA_BYTES - 1);

  frame_state_e          state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  frame_data_t           shreg_q, shreg_d;
  frame_data_t           out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_timeout_q;
  logic                  err_overrun_q, err_overrun_d;

  logic                  timeout_c;
  logic                  frame_done_c;
  frame_data_t           frame_data_c;
`ifdef FRAME_CHECKSUM_EN
  logic                  csum_err_c;
  logic                  err_checksum_q;
`endif

  uart_frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .active_i     (state_q != HUNT),
    .byte_valid_i (byte_valid),
    .expire_c     (timeout_c)
  );

  // Parser next-state: header hunt, payload assembly, optional checksum byte.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shreg_d      = shreg_q;
    frame_done_c = 1'b0;
    frame_data_c = shreg_q;
`ifdef FRAME_CHECKSUM_EN
    csum_err_c   = 1'b0;
`endif
    if (timeout_c) begin
      state_d    = HUNT;
      byte_cnt_d = '0;
    end else if (byte_valid) begin
      unique case (state_q)
        HUNT: begin
          if (byte_in == HDR0) begin
            state_d = HDR;
          end
        end
        HDR: begin
          if (byte_in == HDR1) begin
            state_d    = DATA;
            byte_cnt_d = '0;
          end else if (byte_in != HDR0) begin
            state_d = HUNT;
          end
        end
        DATA: begin
          shreg_d    = {shreg_q[FRAME_DATA_W-9:0], byte_in};
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          if (byte_cnt_q == CNT_LAST) begin
            byte_cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d      = HUNT;
            frame_done_c = 1'b1;
            frame_data_c = shreg_d;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: begin
          state_d = HUNT;
          if (byte_in == frame_xor(shreg_q)) begin
            frame_done_c = 1'b1;
            frame_data_c = shreg_q;
          end else begin
            csum_err_c = 1'b1;
          end
        end
`endif
        default: begin
          state_d    = HUNT;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  // Output holding register: a frame that cannot be delivered is dropped.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    err_overrun_d = 1'b0;
    if (frame_done_c) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = frame_data_c;
      end else begin
        err_overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      byte_cnt_q    <= '0;
      shreg_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shreg_q       <= shreg_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      err_timeout_q <= timeout_c;
      err_overrun_q <= err_overrun_d;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_checksum_q <= 1'b0;
    end else begin
      err_checksum_q <= csum_err_c;
    end
  end
  assign err_checksum = err_checksum_q;
`else
  assign err_checksum = 1'b0;
`endif

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed plus randomized bench for uart_frame_rx; the expected payloads come
// from the frames the bench itself builds and sends.
module tb_uart_frame_rx;

  localparam int unsigned TMO = 50;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_checksum;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] got_q[$];
  int          n_tmo, n_ovr, n_csum;

  always #5 clk = ~clk;

  uart_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .err_checksum (err_checksum)
  );

  // Record accepted payloads and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (err_timeout)  n_tmo++;
      if (err_overrun)  n_ovr++;
      if (err_checksum) n_csum++;
    end
  end

  task automatic clr_mon();
    got_q.delete();
    n_tmo  = 0;
    n_ovr  = 0;
    n_csum = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_q(input bq_t q, input int max_gap);
    foreach (q[i]) begin
      if (i != 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(q[i]);
    end
  endtask

  // Reference frame: header, payload bytes MSB first, optional XOR byte.
  function automatic bq_t build_frame(input logic [63:0] d);
    bq_t q;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    q = {};
    q.push_back(8'h4D);
    q.push_back(8'h43);
    for (int i = 7; i >= 0; i--) begin
      q.push_back(d[i*8 +: 8]);
`ifdef FRAME_CHECKSUM_EN
      x = x ^ d[i*8 +: 8];
`endif
    end
`ifdef FRAME_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    bq_t         q;
    logic [63:0] a, b, exp_q[$];
    logic [7:0]  last, junk;
    int          gap;

    rst        = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    out_ready  = 1'b1;
    clr_mon();

    // Reset state
    idle(3);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_errs", {61'd0, err_timeout, err_overrun, err_checksum}, 64'd0);
    rst = 1'b1;
    idle(2);

    // Basic frame with one-cycle completion latency
    send_q(build_frame(64'h0123456789ABCDEF), 0);
    chk("basic_valid_lat", 64'(out_valid), 64'd1);
    chk("basic_data", out_data, 64'h0123456789ABCDEF);
    idle(2);
    chk("basic_valid_drop", 64'(out_valid), 64'd0);
    chk("basic_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("basic_got", got_q[0], 64'h0123456789ABCDEF);
    chk("basic_errs", 64'(n_tmo + n_ovr + n_csum), 64'd0);
    clr_mon();

    // Leading junk and repeated first header byte
    q = build_frame(64'h1111111111111111);
    q.push_front(8'h4D);
    q.push_front(8'h00);
    send_q(q, 0);
    idle(2);
    chk("resync_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("resync_got", got_q[0], 64'h1111111111111111);
    clr_mon();

    // Timeout after exactly TMO idle cycles inside a frame
    send_q('{8'h4D, 8'h43, 8'h01, 8'h02, 8'h03}, 0);
    idle(TMO - 1);
    chk("tmo_before", 64'(err_timeout), 64'd0);
    idle(1);
    chk("tmo_pulse", 64'(err_timeout), 64'd1);
    idle(1);
    chk("tmo_after", 64'(err_timeout), 64'd0);
    chk("tmo_count", 64'(n_tmo), 64'd1);
    chk("tmo_no_frame", 64'(got_q.size()), 64'd0);
    a = rnd64();
    send_q(build_frame(a), 2);
    idle(2);
    chk("tmo_next_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("tmo_next_got", got_q[0], a);
    clr_mon();

    // A byte landing in the expiry cycle is kept
    a = rnd64();
    q = build_frame(a);
    foreach (q[i]) begin
      if (i != 0) idle(TMO - 1);
      send_byte(q[i]);
    end
    idle(2);
    chk("edge_tmo_none", 64'(n_tmo), 64'd0);
    chk("edge_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("edge_got", got_q[0], a);
    clr_mon();

    // Overrun: second frame dropped while first is held
    out_ready = 1'b0;
    a = rnd64();
    b = rnd64();
    send_q(build_frame(a), 1);
    send_q(build_frame(b), 1);
    idle(2);
    chk("ovr_valid", 64'(out_valid), 64'd1);
    chk("ovr_data", out_data, a);
    chk("ovr_count", 64'(n_ovr), 64'd1);
    out_ready = 1'b1;
    idle(1);
    chk("ovr_drop", 64'(out_valid), 64'd0);
    chk("ovr_acc_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("ovr_acc_got", got_q[0], a);
    clr_mon();

    // Completion coinciding with acceptance replaces the held frame
    out_ready = 1'b0;
    a = rnd64();
    b = rnd64();
    send_q(build_frame(a), 0);
    q = build_frame(b);
    last = q.pop_back();
    send_q(q, 0);
    out_ready = 1'b1;
    send_byte(last);
    chk("same_valid", 64'(out_valid), 64'd1);
    chk("same_data", out_data, b);
    idle(1);
    chk("same_drop", 64'(out_valid), 64'd0);
    chk("same_ovr", 64'(n_ovr), 64'd0);
    chk("same_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() > 1) begin
      chk("same_got0", got_q[0], a);
      chk("same_got1", got_q[1], b);
    end
    clr_mon();

    // Asynchronous reset mid-payload with a frame still held
    out_ready = 1'b0;
    send_q(build_frame(rnd64()), 0);
    send_q('{8'h4D, 8'h43, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25}, 0);
    rst = 1'b0;
    #2;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_errs", {61'd0, err_timeout, err_overrun, err_checksum}, 64'd0);
    idle(2);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send_q('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("midrst_stale", 64'(got_q.size()), 64'd0);
    a = rnd64();
    send_q(build_frame(a), 1);
    idle(2);
    chk("midrst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("midrst_got", got_q[0], a);
    clr_mon();

`ifdef FRAME_CHECKSUM_EN
    // Checksum good and bad
    send_q(build_frame(64'h0102030405060708), 0);
    idle(2);
    chk("csum_ok_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("csum_ok_got", got_q[0], 64'h0102030405060708);
    clr_mon();
    q = build_frame(64'h0102030405060708);
    last = q.pop_back();
    q.push_back(8'h09);
    send_q(q, 0);
    chk("csum_bad_pulse", 64'(err_checksum), 64'd1);
    chk("csum_bad_valid", 64'(out_valid), 64'd0);
    idle(2);
    chk("csum_bad_count", 64'(n_csum), 64'd1);
    chk("csum_bad_none", 64'(got_q.size()), 64'd0);
    clr_mon();
`endif

    // Randomized frames separated by junk, payloads may contain header values
    exp_q = {};
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h4D) junk = 8'h00;
        send_byte(junk);
      end
      a = (f % 5 == 0) ? 64'h4D434D434D434D43 : rnd64();
      exp_q.push_back(a);
      q = build_frame(a);
      foreach (q[i]) begin
        gap = ($urandom_range(0, 7) == 0) ? int'(TMO) - 1 : int'($urandom_range(0, 3));
        if (i != 0) idle(gap);
        send_byte(q[i]);
      end
    end
    idle(3);
    chk("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rand_frame%0d", i), got_q[i], exp_q[i]);
    end
    chk("rand_errs", 64'(n_tmo + n_ovr + n_csum), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
